risk_unit: RTL
==============

# risk_unit

Hazard ("risk") detection and pipeline-freeze controller in the decode stage. Compares the ID-stage source registers against EX/MEM destinations and produces `o_Risk` for the control-signal bubble mux. It also produces PC and IF/ID write-enables and the IF/ID flush for taken branches and jumps. A small FSM sequences multi-cycle stalls and drains the pipeline after HALT, and all sequential state is gated by the debug step enable.

## Interface
- `REG_ADDR_W`, 5: register-address width.
- `DRAIN_CYCLES`, 3: cycles from HALT leaving ID to HALT retiring in WB.
- `CNT_W`, 3: stall/drain counter width; must satisfy 2^CNT_W > DRAIN_CYCLES.

Ports:
- `i_clk`  in  1  Clock; single clock domain.
- `i_reset`  in  1  Reset, synchronous and active-high.
- `i_Step`  in  1  Pipeline advance enable (debug unit); 0 freezes everything.
- `i_ID_Rs`, `i_ID_Rt`  in  REG_ADDR_W  Source registers of the instruction in ID.
- `i_ID_UsesRt`  in  1  Instruction in ID reads Rt.
- `i_ID_Branch`, `i_ID_NBranch`, `i_ID_JALR`  in  1  ID instruction compares or reads registers in ID.
- `i_ID_HALT`  in  1  Instruction in ID is HALT.
- `i_ID_Taken`  in  1  Branch taken, jump, or JALR resolved in ID.
- `i_EX_MemRead`, `i_EX_RegWrite`  in  1  EX-stage control.
- `i_EX_Rd`  in  REG_ADDR_W  EX destination, after the RegDst/JAL select.
- `i_MEM_MemRead`  in  1  MEM stage is a load.
- `i_MEM_Rd`  in  REG_ADDR_W  MEM destination.
- `o_Risk`  out  1  Bubble request to the control mux.
- `o_PCWrite`  out  1  PC update enable.
- `o_IFIDWrite`  out  1  IF/ID register enable.
- `o_IFIDFlush`  out  1  Clear IF/ID.
- `o_Halted`  out  1  Pipeline drained after HALT; sticky.

## Operation
- Match definitions:
  - `mRs(x)` = (x != 0) && (x == i_ID_Rs).
  - `mRt(x)` = (x != 0) && i_ID_UsesRt && (x == i_ID_Rt).
  - `m(x)` = `mRs(x)` || `mRt(x)`.
  - `RegRd` = i_ID_Branch | i_ID_NBranch | i_ID_JALR.
- Stall need `N`, evaluated in RUN only:
  - N = 2 if `RegRd` && i_EX_MemRead && `m(i_EX_Rd)`.
  - Else N = 1 if (i_EX_MemRead && `m(i_EX_Rd)`) or (`RegRd` && i_EX_RegWrite && `m(i_EX_Rd)`) or (`RegRd` && i_MEM_MemRead && `m(i_MEM_Rd)`).
  - Else N = 0.
- FSM states: RUN, STALL, DRAIN, HALTED. Counter `cnt` is CNT_W bits.
- RUN:
  - If N > 0: o_Risk = 1, o_PCWrite = 0, o_IFIDWrite = 0, o_IFIDFlush = 0. If N == 2, set cnt = 1 and go to STALL; otherwise stay in RUN.
  - Else if i_ID_HALT: o_Risk = 0, o_PCWrite = 0, o_IFIDWrite = 0. Set cnt = DRAIN_CYCLES and go to DRAIN. HALT propagates to EX unbubbled.
  - Else: o_PCWrite = 1, o_IFIDWrite = 1, o_IFIDFlush = i_ID_Taken.
- STALL: o_Risk = 1, o_PCWrite = 0, o_IFIDWrite = 0. Decrement cnt; when cnt == 1, go to RUN. The hazard is re-evaluated in RUN on the next cycle.
- DRAIN: o_Risk = 1 (bubbles behind HALT), o_PCWrite = 0, o_IFIDWrite = 0. Decrement cnt; when cnt == 1, go to HALTED.
- HALTED: o_Halted = 1, o_Risk = 1, o_PCWrite = 0, o_IFIDWrite = 0. Only reset exits this state.
- Priority: a stall outranks HALT and taken-flush. Flush is never asserted while stalling.
- i_Step = 0:
  - State and cnt hold.
  - o_PCWrite, o_IFIDWrite, o_IFIDFlush and o_Risk are all 0.
  - o_Halted keeps its value.
- Register 0 never causes a hazard.

## Timing
- Reset (synchronous): next edge sets state = RUN, cnt = 0, o_Halted = 0. While i_reset is high, o_Risk, o_PCWrite, o_IFIDWrite and o_IFIDFlush are all 0.
- Reset asserted mid-STALL or mid-DRAIN aborts the sequence. The pending stall is dropped.
- Stall, flush and write-enable outputs are combinational from state plus ID/EX/MEM inputs, effective in the same cycle.
- State and cnt update only on edges where i_Step = 1.
- Stall lengths:
  - Load-use: 1 bubble.
  - ALU result feeding a branch: 1 bubble.
  - Load feeding a branch: 2 bubbles, the second from STALL.
  - Load in MEM feeding a branch: 1 bubble.
- HALT: o_Halted rises exactly DRAIN_CYCLES+1 stepped edges after the edge where HALT sat in ID in RUN.
- A step gap (i_Step = 0) mid-stall extends wall time but not the bubble count.

## Test plan
- Load-use: EX lw Rd = 5, MemRead = 1; ID add Rs = 5, UsesRt = 0 -> o_Risk = 1 and o_PCWrite = 0 for exactly one cycle, then o_PCWrite = 1.
- Load-branch: EX lw Rd = 3; ID beq Rs = 3, Branch = 1 -> o_Risk = 1 for 2 consecutive cycles, FSM passes through STALL, o_IFIDFlush = 0 throughout.
- Register 0 and ALU-only: EX add Rd = 0 with RegWrite = 1; ID beq Rs = 0 -> no stall. Then ID add Rs = 4, EX add Rd = 4 (no load, no branch) -> no stall.
- Taken branch, no hazard: i_ID_Taken = 1 -> o_IFIDFlush = 1 for one cycle, o_PCWrite = 1.
- HALT with DRAIN_CYCLES = 3: i_ID_HALT in RUN -> o_Halted = 1 after 4 stepped edges and held. Hold i_Step = 0 for 2 cycles mid-drain -> o_Halted rises 2 cycles later.
- Reset mid-STALL (load-branch case, reset after the first bubble) -> next cycle RUN, o_Risk = 0, o_Halted = 0.

Source files
------------

// File: rtl/risk_unit_if.sv
// Decode-stage hazard controller bus.
// The pipeline side drives the ID/EX/MEM view and the controller returns the freeze and flush controls.
interface risk_unit_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  step;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic                  id_branch;
    logic                  id_nbranch;
    logic                  id_jalr;
    logic                  id_halt;
    logic                  id_taken;
    logic                  ex_mem_read;
    logic                  ex_reg_write;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  mem_mem_read;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  risk;
    logic                  pc_write;
    logic                  ifid_write;
    logic                  ifid_flush;
    logic                  halted;

    modport master (
        output step, id_rs, id_rt, id_uses_rt, id_branch, id_nbranch, id_jalr,
               id_halt, id_taken, ex_mem_read, ex_reg_write, ex_rd,
               mem_mem_read, mem_rd,
        input  risk, pc_write, ifid_write, ifid_flush, halted
    );

    modport slave (
        input  step, id_rs, id_rt, id_uses_rt, id_branch, id_nbranch, id_jalr,
               id_halt, id_taken, ex_mem_read, ex_reg_write, ex_rd,
               mem_mem_read, mem_rd,
        output risk, pc_write, ifid_write, ifid_flush, halted
    );
endinterface

// File: rtl/risk_unit.sv
// Decode-stage hazard detection and pipeline-freeze controller.
// Handles load-use and branch-operand stalls, taken-branch flush, and post-HALT drain.
module risk_unit #(
    parameter int REG_ADDR_W   = 5,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    risk_unit_if.slave  bus
);
    typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             reg_rd, m_ex, m_mem, need2, need1;
    logic             risk_c, pc_write_c, ifid_write_c, ifid_flush_c;

    // Register 0 is hardwired, so it never creates a dependency.
    assign m_ex  = (bus.ex_rd != ZERO_REG) &&
                   ((bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));
    assign m_mem = (bus.mem_rd != ZERO_REG) &&
                   ((bus.mem_rd == bus.id_rs) || (bus.id_uses_rt && (bus.mem_rd == bus.id_rt)));

    assign reg_rd = bus.id_branch | bus.id_nbranch | bus.id_jalr;
    assign need2  = reg_rd && bus.ex_mem_read && m_ex;
    assign need1  = (bus.ex_mem_read && m_ex) ||
                    (reg_rd && bus.ex_reg_write && m_ex) ||
                    (reg_rd && bus.mem_mem_read && m_mem);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        risk_c       = 1'b0;
        pc_write_c   = 1'b0;
        ifid_write_c = 1'b0;
        ifid_flush_c = 1'b0;
        case (state)
            RUN: begin
                if (need2 || need1) begin
                    risk_c = 1'b1;
                    if (need2) begin
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = STALL;
                    end
                end else if (bus.id_halt) begin
                    // HALT itself goes down unbubbled; bubbles follow from DRAIN.
                    cnt_nxt   = CNT_W'(DRAIN_CYCLES);
                    state_nxt = DRAIN;
                end else begin
                    pc_write_c   = 1'b1;
                    ifid_write_c = 1'b1;
                    ifid_flush_c = bus.id_taken;
                end
            end
            STALL: begin
                risk_c  = 1'b1;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_nxt = RUN;
            end
            DRAIN: begin
                risk_c  = 1'b1;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_nxt = HALTED;
            end
            HALTED: begin
                risk_c = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        // A frozen or resetting pipeline gets no enables and no bubbles.
        if (i_reset || !bus.step) begin
            risk_c       = 1'b0;
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            ifid_flush_c = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= RUN;
            cnt   <= '0;
        end else if (bus.step) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign bus.risk       = risk_c;
    assign bus.pc_write   = pc_write_c;
    assign bus.ifid_write = ifid_write_c;
    assign bus.ifid_flush = ifid_flush_c;
    assign bus.halted     = (state == HALTED);
endmodule
